// File: rtl/rpn_exec_unit.sv
// RPN execute stage: pops B then A from the input stack, applies one ALU op, presents a WIDTH-bit result.
// Optional iterative unsigned divider enabled by defining RPN_DIV_EN; without it op 011 is rejected as illegal.
module rpn_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] stack_data,
  input  logic             stack_have_data,
  output logic             pop,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [1:0]       err
);

  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("CNT_W too narrow to count WIDTH divider steps");
  end

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_DIVZ  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    CHK_B,
    POP_B,
    CAP_B,
    CHK_A,
    POP_A,
    CAP_A,
    EXEC,
`ifdef RPN_DIV_EN
    DIV_LOOP,
`endif
    DONE,
    ERR
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu;
  logic             illegal_op;

`ifdef RPN_DIV_EN
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  assign illegal_op = 1'b0;

  // Restoring step: shift next dividend bit into the remainder, subtract B if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_nxt  = rem_sh[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nxt  = rem_diff[WIDTH-1:0];
      quo_nxt  = {quo_q[WIDTH-2:0], 1'b1};
    end
  end
`else
  assign illegal_op = (op == OP_DIV);
`endif

  always_comb begin
    alu = a_q;
    case (op_q)
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_MUL:  alu = a_q * b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      OP_PASS: alu = a_q;
      default: alu = a_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = illegal_op ? ERR : CHK_B;
      CHK_B: state_nxt = stack_have_data ? POP_B : ERR;
      POP_B: state_nxt = CAP_B;
      CAP_B: state_nxt = CHK_A;
      // haveData here already reflects the B pop
      CHK_A: state_nxt = stack_have_data ? POP_A : ERR;
      POP_A: state_nxt = CAP_A;
      CAP_A: state_nxt = EXEC;
`ifdef RPN_DIV_EN
      EXEC: begin
        if (op_q == OP_DIV) state_nxt = (b_q == '0) ? ERR : DIV_LOOP;
        else                state_nxt = DONE;
      end
      DIV_LOOP: if (cnt_q == CNT_W'(1)) state_nxt = DONE;
`else
      EXEC:  state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pop          = (state == POP_B) || (state == POP_A);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      err    <= ERR_OK;
`ifdef RPN_DIV_EN
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            err  <= illegal_op ? ERR_ILL : ERR_OK;
          end
        end
        CHK_B: if (!stack_have_data) err <= ERR_UNDER;
        CAP_B: b_q <= stack_data;
        CHK_A: if (!stack_have_data) err <= ERR_UNDER;
        CAP_A: a_q <= stack_data;
`ifdef RPN_DIV_EN
        EXEC: begin
          if (op_q == OP_DIV) begin
            if (b_q == '0) begin
              err <= ERR_DIVZ;
            end else begin
              rem_q <= '0;
              quo_q <= a_q;
              cnt_q <= CNT_W'(WIDTH);
            end
          end else begin
            result <= alu;
          end
        end
        DIV_LOOP: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) result <= quo_nxt;
        end
`else
        EXEC: result <= alu;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_exec_unit.sv
// Directed bench for rpn_exec_unit: a small stack model feeds operands, and a spec-level
// timeline model predicts pop/busy/result_valid/result/err for every cycle of each op.
module tb_rpn_exec_unit;
  localparam int WIDTH = 32;
`ifdef RPN_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] stack_data = '0;
  logic             stack_have_data;
  logic             pop;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic [1:0]       err;

  rpn_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .stack_data(stack_data), .stack_have_data(stack_have_data),
    .pop(pop), .result(result), .result_valid(result_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Stack: registered output, popped word appears the cycle after pop.
  logic [WIDTH-1:0] mem [0:1];
  int               sp = 0;
  logic             ld = 1'b0;
  int               ld_n = 0;
  logic [WIDTH-1:0] ld_top = '0, ld_next = '0;

  always @(posedge clk) begin
    if (ld) begin
      sp <= ld_n;
      if (ld_n == 2) begin
        mem[1] <= ld_top;
        mem[0] <= ld_next;
      end else if (ld_n == 1) begin
        mem[0] <= ld_top;
      end
    end else if (pop && sp > 0) begin
      stack_data <= mem[sp-1];
      sp         <= sp - 1;
    end
  end
  assign stack_have_data = (sp != 0);

  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] m_result = '0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_alu(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (o)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Loads the stack (n words, top first), issues one start, and checks every cycle
  // from the accepting edge until one cycle after the op retires.
  task automatic run_op(input logic [2:0] o, input int n, input logic [WIDTH-1:0] top,
                        input logic [WIDTH-1:0] nxt, input bit poke_busy);
    int p1, p2, vcyc, err_cyc, end_cyc, rem;
    logic [1:0]       fin_err;
    logic [WIDTH-1:0] new_res;
    @(negedge clk);
    ld = 1'b1; ld_n = n; ld_top = top; ld_next = nxt;
    @(negedge clk);
    ld = 1'b0;

    p1 = -1; p2 = -1; vcyc = -1; new_res = m_result;
    if (o == 3'd3 && !DIV_EN) begin
      fin_err = 2'b11; err_cyc = 0; end_cyc = 0; rem = n;
    end else if (n == 0) begin
      fin_err = 2'b01; err_cyc = 1; end_cyc = 1; rem = 0;
    end else if (n == 1) begin
      p1 = 1; fin_err = 2'b01; err_cyc = 4; end_cyc = 4; rem = 0;
    end else begin
      p1 = 1; p2 = 4; rem = n - 2;
      if (o == 3'd3 && top == '0) begin
        fin_err = 2'b10; err_cyc = 7; end_cyc = 7;
      end else begin
        fin_err = 2'b00; err_cyc = 0;
        vcyc = (o == 3'd3) ? 7 + WIDTH : 7;
        end_cyc = vcyc;
        new_res = model_alu(o, nxt, top);
      end
    end

    start = 1'b1; op = o;
    @(posedge clk);
    #1 start = 1'b0; op = ~o;
    for (int c = 0; c <= end_cyc + 1; c++) begin
      @(negedge clk);
      chk($sformatf("pop op%0d c%0d", o, c), WIDTH'(pop), WIDTH'((c == p1) || (c == p2)));
      chk($sformatf("busy op%0d c%0d", o, c), WIDTH'(busy), WIDTH'(c <= end_cyc));
      chk($sformatf("result_valid op%0d c%0d", o, c), WIDTH'(result_valid), WIDTH'(c == vcyc));
      chk($sformatf("result op%0d c%0d", o, c), result, (vcyc >= 0 && c >= vcyc) ? new_res : m_result);
      chk($sformatf("err op%0d c%0d", o, c), WIDTH'(err), WIDTH'((c >= err_cyc) ? fin_err : 2'b00));
      if (poke_busy) begin
        if (c == 2) begin start = 1'b1; op = 3'd2; end
        else        start = 1'b0;
      end
    end
    chk($sformatf("stack_depth op%0d", o), WIDTH'(sp), WIDTH'(rem));
    m_result = new_res;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " pop"}, WIDTH'(pop), '0);
    chk({tag, " busy"}, WIDTH'(busy), '0);
    chk({tag, " result_valid"}, WIDTH'(result_valid), '0);
    chk({tag, " result"}, result, '0);
    chk({tag, " err"}, WIDTH'(err), '0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 3'd0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 chk("start_during_reset busy", WIDTH'(busy), '0);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;

    run_op(3'd0, 2, 32'd7, 32'd5, 1'b0);
    chk("add literal", result, 32'h0000000C);
    run_op(3'd1, 2, 32'd9, 32'd4, 1'b0);
    chk("sub literal", result, 32'hFFFFFFFB);
    run_op(3'd2, 2, 32'd3, 32'h8000, 1'b0);
    chk("mul literal", result, 32'h00018000);
    run_op(3'd4, 2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0);
    chk("and literal", result, 32'h00F0_F000);
    run_op(3'd5, 2, 32'hF000_0001, 32'h0000_1000, 1'b0);
    run_op(3'd6, 2, 32'hFFFF_0000, 32'h1234_5678, 1'b0);
    chk("xor literal", result, 32'hEDCB_5678);
    run_op(3'd7, 2, 32'h1111_1111, 32'hCAFE_BABE, 1'b0);
    run_op(3'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul wrap literal", result, 32'h00000001);

    run_op(3'd3, 2, 32'd3, 32'd100, 1'b0);
`ifdef RPN_DIV_EN
    chk("div literal", result, 32'd33);
    run_op(3'd3, 2, 32'd0, 32'd5, 1'b0);
    run_op(3'd3, 2, 32'd7, 32'hFFFF_FFFF, 1'b0);
`else
    chk("illegal div err", WIDTH'(err), WIDTH'(2'b11));
`endif

    run_op(3'd0, 1, 32'd6, 32'd0, 1'b0);
    run_op(3'd0, 0, 32'd0, 32'd0, 1'b0);
    run_op(3'd0, 2, 32'd40, 32'd2, 1'b1);

    // Abort in POP_A: everything must clear asynchronously.
    @(negedge clk);
    ld = 1'b1; ld_n = 2; ld_top = 32'd11; ld_next = 32'd22;
    @(negedge clk);
    ld = 1'b0; start = 1'b1; op = 3'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("pre_reset pop", WIDTH'(pop), WIDTH'(1));
    reset = 1'b1;
    #1 check_reset_outputs("reset_pop_a");
    @(negedge clk);
    reset = 1'b0;
    m_result = '0;
    run_op(3'd0, 2, 32'd1, 32'd2, 1'b0);
    chk("post_reset add literal", result, 32'd3);

`ifdef RPN_DIV_EN
    @(negedge clk);
    ld = 1'b1; ld_n = 2; ld_top = 32'd3; ld_next = 32'd100;
    @(negedge clk);
    ld = 1'b0; start = 1'b1; op = 3'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_div_loop");
    @(negedge clk);
    reset = 1'b0;
    m_result = '0;
    run_op(3'd3, 2, 32'd4, 32'd19, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
